// File: rtl/uart_tx_serializer.sv
// UART transmitter, 8N1/8N2, LSB first, registered line output, valid/ready byte intake.
// Optional parity bit after D7 when UART_TX_PARITY_EN is defined (even, or odd via PARITY_ODD).
module uart_tx_serializer #(
  parameter int CLK_FREQ   = 50_000_000,
  parameter int BAUD_RATE  = 9600,
  parameter int STOP_BITS  = 1,
  parameter bit PARITY_ODD = 1'b0
) (
  input  logic       i_clk_sys,
  input  logic       i_rst,
  input  logic [7:0] i_tx_data,
  input  logic       i_tx_valid,
  output logic       o_tx_ready,
  output logic       o_tx,
  output logic       o_tx_busy,
  output logic       o_tx_done
);

  localparam int            BIT_CYCLES = CLK_FREQ / BAUD_RATE;
  localparam int            CW         = $clog2(BIT_CYCLES);
  localparam logic [CW-1:0] CNT_MAX    = CW'(BIT_CYCLES - 1);
  localparam logic [2:0]    LAST_STOP  = 3'(STOP_BITS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
`ifdef UART_TX_PARITY_EN
    S_PARITY,
`endif
    S_STOP
  } state_t;

  state_t        state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [2:0]    idx, idx_n;
  logic [7:0]    sh, sh_n;
  logic          tx_q, tx_n;
  logic          done_q, done_n;
  logic          bit_end;

`ifdef UART_TX_PARITY_EN
  logic par_q, par_n;

  always_ff @(posedge i_clk_sys or posedge i_rst) begin
    if (i_rst) par_q <= 1'b0;
    else       par_q <= par_n;
  end
`else
  logic unused_parity_odd;
  assign unused_parity_odd = PARITY_ODD;
`endif

  always_ff @(posedge i_clk_sys or posedge i_rst) begin
    if (i_rst) begin
      state  <= S_IDLE;
      cnt    <= '0;
      idx    <= '0;
      sh     <= '0;
      tx_q   <= 1'b1;
      done_q <= 1'b0;
    end else begin
      state  <= state_n;
      cnt    <= cnt_n;
      idx    <= idx_n;
      sh     <= sh_n;
      tx_q   <= tx_n;
      done_q <= done_n;
    end
  end

  assign bit_end = (cnt == CNT_MAX);

  // tx_n is the line level for the next cycle, so o_tx leads straight from a flop.
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    idx_n   = idx;
    sh_n    = sh;
    tx_n    = tx_q;
    done_n  = 1'b0;
`ifdef UART_TX_PARITY_EN
    par_n   = par_q;
`endif
    if (state != S_IDLE) begin
      cnt_n = bit_end ? '0 : cnt + CW'(1);
    end
    case (state)
      S_IDLE: begin
        tx_n = 1'b1;
        if (i_tx_valid) begin
          state_n = S_START;
          sh_n    = i_tx_data;
          cnt_n   = '0;
          idx_n   = '0;
          tx_n    = 1'b0;
`ifdef UART_TX_PARITY_EN
          par_n   = PARITY_ODD ? ~^i_tx_data : ^i_tx_data;
`endif
        end
      end
      S_START: begin
        if (bit_end) begin
          state_n = S_DATA;
          tx_n    = sh[0];
        end
      end
      S_DATA: begin
        if (bit_end) begin
          if (idx == 3'd7) begin
            idx_n = '0;
`ifdef UART_TX_PARITY_EN
            state_n = S_PARITY;
            tx_n    = par_q;
`else
            state_n = S_STOP;
            tx_n    = 1'b1;
`endif
          end else begin
            idx_n = idx + 3'd1;
            sh_n  = {1'b0, sh[7:1]};
            tx_n  = sh[1];
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      S_PARITY: begin
        if (bit_end) begin
          state_n = S_STOP;
          tx_n    = 1'b1;
        end
      end
`endif
      S_STOP: begin
        tx_n = 1'b1;
        if (bit_end) begin
          if (idx == LAST_STOP) begin
            state_n = S_IDLE;
            idx_n   = '0;
            done_n  = 1'b1;
          end else begin
            idx_n = idx + 3'd1;
          end
        end
      end
      default: begin
        state_n = S_IDLE;
        tx_n    = 1'b1;
      end
    endcase
  end

  assign o_tx       = tx_q;
  assign o_tx_done  = done_q;
  assign o_tx_ready = (state == S_IDLE);
  assign o_tx_busy  = (state != S_IDLE);

endmodule

// File: tb/tb_uart_tx_serializer.sv
// Bench for uart_tx_serializer at 16 clocks per bit: stimulus queues expected bytes,
// a line monitor decodes each frame at mid-bit and checks it against the queue.
module tb_uart_tx_serializer;

  localparam int BC = 16;
`ifdef UART_TX_PARITY_EN
  localparam int PB = 1;
`else
  localparam int PB = 0;
`endif
  localparam int NB = 1 + 8 + PB + 1;

  logic       clk   = 1'b0;
  logic       rst   = 1'b1;
  logic [7:0] data  = 8'h00;
  logic       valid = 1'b0;
  logic       ready, tx, busy, done;

  int         checks    = 0;
  int         failures  = 0;
  int         done_cnt  = 0;
  int         last_gap  = 0;
  longint     cyc       = 0;
  longint     last_done = -100;
  logic [7:0] exp_q[$];

  uart_tx_serializer #(
    .CLK_FREQ  (160),
    .BAUD_RATE (10),
    .STOP_BITS (1),
    .PARITY_ODD(1'b0)
  ) dut (
    .i_clk_sys (clk),
    .i_rst     (rst),
    .i_tx_data (data),
    .i_tx_valid(valid),
    .o_tx_ready(ready),
    .o_tx      (tx),
    .o_tx_busy (busy),
    .o_tx_done (done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
    end
  endtask

  // Line monitor: frame-relative cycle m_c, bit b is sampled at b*BC + BC/2.
  bit         m_act = 1'b0;
  int         m_c   = 0;
  logic [7:0] m_byte = 8'h00;
  logic       m_par  = 1'b0;
  logic [7:0] e;
  int         b;

  always @(negedge clk) begin
    if (rst) begin
      m_act = 1'b0;
    end else begin
      if (!m_act) begin
        if (done) chk("spurious_done", 32'(done), 32'd0);
        if (tx == 1'b0) begin
          m_act    = 1'b1;
          m_c      = 0;
          last_gap = int'(cyc - last_done);
        end
      end else begin
        m_c++;
      end
      if (m_act) begin
        if (m_c % BC == BC / 2) begin
          b = m_c / BC;
          if (b == 0)                   chk("start_bit", 32'(tx), 32'd0);
          else if (b <= 8)              m_byte[b-1] = tx;
          else if (PB == 1 && b == 9)   m_par = tx;
          else                          chk("stop_bit", 32'(tx), 32'd1);
          chk("busy_ready_mid", 32'({busy, ready, done}), 32'b100);
        end
        if (m_c == NB * BC) begin
          chk("done_pulse", 32'({done, busy, ready}), 32'b101);
          checks++;
          if (exp_q.size() == 0) begin
            failures++;
            $display("FAIL unexpected_frame actual=0x%0h required=none", m_byte);
          end else begin
            e = exp_q.pop_front();
            if (m_byte !== e) begin
              failures++;
              $display("FAIL rx_byte actual=0x%0h required=0x%0h", m_byte, e);
            end
`ifdef UART_TX_PARITY_EN
            chk("parity_bit", 32'(m_par), 32'(^e));
`endif
          end
          done_cnt++;
          last_done = cyc;
          m_act     = 1'b0;
        end else if (done) begin
          chk("early_done", 32'(done), 32'd0);
        end
      end
    end
  end

  task automatic wait_clks(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send(input logic [7:0] byt, input bit expect_it);
    int t;
    t = 0;
    @(negedge clk);
    while (!ready && t < 2 * NB * BC) begin
      @(negedge clk);
      t++;
    end
    if (!ready) chk("ready_timeout", 32'(ready), 32'd1);
    data  = byt;
    valid = 1'b1;
    if (expect_it) exp_q.push_back(byt);
    @(posedge clk);
    #1;
    valid = 1'b0;
    data  = ~byt;
    chk("start_latency", 32'({tx, busy, ready}), 32'b010);
  endtask

  task automatic wait_done();
    int t;
    t = 0;
    do begin
      @(negedge clk);
      t++;
    end while (!done && t < 2 * NB * BC);
    if (!done) chk("done_timeout", 32'(done), 32'd1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    repeat (5) begin
      @(negedge clk);
      chk("reset_outputs", 32'({tx, ready, busy, done}), 32'b1100);
    end
    rst = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk("idle_outputs", 32'({tx, ready, busy, done}), 32'b1100);
    end

    send(8'h5A, 1'b1);
    wait_done();
    #1 chk("done_count_5a", 32'(done_cnt), 32'd1);

    send(8'h00, 1'b1);
    wait_done();
    data  = 8'hFF;
    valid = 1'b1;
    exp_q.push_back(8'hFF);
    @(posedge clk);
    #1;
    valid = 1'b0;
    chk("b2b_start_latency", 32'({tx, busy, ready}), 32'b010);
    wait_done();
    #1;
    chk("b2b_gap", 32'(last_gap), 32'd1);
    chk("done_count_b2b", 32'(done_cnt), 32'd3);

    send(8'hC3, 1'b1);
    wait_clks(3 * BC);
    data  = 8'h33;
    valid = 1'b1;
    wait_clks(2 * BC);
    valid = 1'b0;
    wait_done();
    #1 chk("done_count_c3", 32'(done_cnt), 32'd4);
    wait_clks(2 * BC);
    chk("ignored_33_done", 32'(done_cnt), 32'd4);
    chk("queue_empty_c3", 32'(exp_q.size()), 32'd0);

    send(8'h81, 1'b0);
    wait_clks(70);
    #2 rst = 1'b1;
    #1 chk("abort_line", 32'({tx, busy, ready, done}), 32'b1010);
    wait_clks(3);
    rst = 1'b0;
    wait_clks(2 * BC);
    chk("abort_no_done", 32'(done_cnt), 32'd4);

    send(8'hA5, 1'b1);
    wait_done();
    #1;
    chk("done_count_a5", 32'(done_cnt), 32'd5);
    wait_clks(4);
    chk("queue_empty_end", 32'(exp_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
